// File: rtl/reg_write_arbiter.sv
// Single-port register-file write arbiter: WB > ISR save > NoC > RAND refresh.
// Grants are registered, so a write granted in one cycle reaches the register file the next.
module reg_write_arbiter #(
    parameter int ISR_REG     = 30,
    parameter int RAND_REG    = 31,
    parameter int RAND_PERIOD = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_WE,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    input  logic        ISR_REQ,
    input  logic [31:0] ISR_PC,
    input  logic [31:0] RAND_IN,
    input  logic        NOC_VALID,
    input  logic [4:0]  NOC_ADDR,
    input  logic [31:0] NOC_DATA,
    output logic        NOC_READY,
    output logic        NOC_ERR,
    output logic        ISR_ACK,
    output logic        RAND_OVERRUN,
    output logic        WRITE_EN,
    output logic [4:0]  IN_ADDRESS,
    output logic [31:0] DATA_IN
);
    localparam int            CW          = (RAND_PERIOD > 2) ? $clog2(RAND_PERIOD) : 1;
    localparam logic [CW-1:0] RAND_RELOAD = CW'(RAND_PERIOD - 1);
    localparam logic [4:0]    ISR_ADDR    = 5'(ISR_REG);
    localparam logic [4:0]    RAND_ADDR   = 5'(RAND_REG);

    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_ACK, ST_WAIT} isr_state_t;

    isr_state_t    r_state;
    isr_state_t    w_state_next;
    logic [CW-1:0] r_rand_cnt;
    logic          r_rand_pending;
    logic          r_rand_overrun;
    logic          r_we;
    logic [4:0]    r_addr;
    logic [31:0]   r_data;
    logic          r_noc_err;

    logic          w_wb_valid;
    logic          w_isr_valid;
    logic          w_noc_grant;
    logic          w_noc_bad;
    logic          w_rand_expire;
    logic          w_isr_grant;
    logic          w_rand_grant;
    logic          w_we_next;
    logic [4:0]    w_addr_next;
    logic [31:0]   w_data_next;

    assign w_wb_valid    = WB_WE && (WB_ADDR != 5'd0);
    assign w_isr_valid   = (r_state == ST_SAVE);
    assign w_noc_grant   = NOC_VALID && !w_wb_valid && !w_isr_valid;
    assign w_noc_bad     = (NOC_ADDR == 5'd0) || (NOC_ADDR == ISR_ADDR) || (NOC_ADDR == RAND_ADDR);
    assign w_rand_expire = (r_rand_cnt == '0);

    // A NoC write to a reserved register still takes the slot; it is just not written.
    always_comb begin
        w_we_next    = 1'b0;
        w_addr_next  = 5'd0;
        w_data_next  = 32'd0;
        w_isr_grant  = 1'b0;
        w_rand_grant = 1'b0;
        if (w_wb_valid) begin
            w_we_next   = 1'b1;
            w_addr_next = WB_ADDR;
            w_data_next = WB_DATA;
        end else if (w_isr_valid) begin
            w_isr_grant = 1'b1;
            w_we_next   = 1'b1;
            w_addr_next = ISR_ADDR;
            w_data_next = ISR_PC;
        end else if (NOC_VALID) begin
            if (!w_noc_bad) begin
                w_we_next   = 1'b1;
                w_addr_next = NOC_ADDR;
                w_data_next = NOC_DATA;
            end
        end else if (r_rand_pending) begin
            w_rand_grant = 1'b1;
            w_we_next    = 1'b1;
            w_addr_next  = RAND_ADDR;
            w_data_next  = RAND_IN;
        end
    end

    // WAIT holds off a new save until ISR_REQ drops, so one request yields one save.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (ISR_REQ) w_state_next = ST_SAVE;
            ST_SAVE: if (w_isr_grant) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_WAIT;
            ST_WAIT: if (!ISR_REQ) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state        <= ST_IDLE;
            r_rand_cnt     <= RAND_RELOAD;
            r_rand_pending <= 1'b0;
            r_rand_overrun <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 5'd0;
            r_data         <= 32'd0;
            r_noc_err      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_we      <= w_we_next;
            r_addr    <= w_addr_next;
            r_data    <= w_data_next;
            r_noc_err <= w_noc_grant && w_noc_bad;

            if (w_rand_expire) r_rand_cnt <= RAND_RELOAD;
            else               r_rand_cnt <= r_rand_cnt - 1'b1;

            // Expiry coinciding with a grant re-arms the request instead of clearing it.
            if (w_rand_grant) begin
                r_rand_pending <= w_rand_expire;
            end else if (w_rand_expire) begin
                r_rand_pending <= 1'b1;
                if (r_rand_pending) r_rand_overrun <= 1'b1;
            end
        end
    end

    assign NOC_READY    = RESET && w_noc_grant;
    assign NOC_ERR      = r_noc_err;
    assign ISR_ACK      = (r_state == ST_ACK);
    assign RAND_OVERRUN = r_rand_overrun;
    assign WRITE_EN     = r_we;
    assign IN_ADDRESS   = r_addr;
    assign DATA_IN      = r_data;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a single-cycle vector table plus
// multi-cycle sequences for ISR save, RAND timing, overrun and reset.
module tb_reg_write_arbiter;
    localparam int P = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WB_WE;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        ISR_REQ;
    logic [31:0] ISR_PC;
    logic [31:0] RAND_IN;
    logic        NOC_VALID;
    logic [4:0]  NOC_ADDR;
    logic [31:0] NOC_DATA;
    logic        NOC_READY;
    logic        NOC_ERR;
    logic        ISR_ACK;
    logic        RAND_OVERRUN;
    logic        WRITE_EN;
    logic [4:0]  IN_ADDRESS;
    logic [31:0] DATA_IN;

    int n_checks = 0;
    int n_errors = 0;

    reg_write_arbiter #(.ISR_REG(30), .RAND_REG(31), .RAND_PERIOD(P)) dut (
        .CLK(CLK), .RESET(RESET),
        .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .ISR_REQ(ISR_REQ), .ISR_PC(ISR_PC), .RAND_IN(RAND_IN),
        .NOC_VALID(NOC_VALID), .NOC_ADDR(NOC_ADDR), .NOC_DATA(NOC_DATA),
        .NOC_READY(NOC_READY), .NOC_ERR(NOC_ERR), .ISR_ACK(ISR_ACK),
        .RAND_OVERRUN(RAND_OVERRUN), .WRITE_EN(WRITE_EN),
        .IN_ADDRESS(IN_ADDRESS), .DATA_IN(DATA_IN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        noc_valid;
        logic [4:0]  noc_addr;
        logic [31:0] noc_data;
        logic        exp_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WB_WE = 1'b0; WB_ADDR = 5'd0; WB_DATA = 32'd0;
        ISR_REQ = 1'b0; ISR_PC = 32'd0; RAND_IN = 32'd0;
        NOC_VALID = 1'b0; NOC_ADDR = 5'd0; NOC_DATA = 32'd0;
    endtask

    // Two reset edges; the next posedge after return is edge 1 after release.
    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b0};
        vecs[2]  = '{1'b1, 5'd9,  32'h00000001, 1'b1, 5'd7,  32'h00000055, 1'b0, 1'b1, 5'd9,  32'h00000001, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  32'h00000055, 1'b1, 1'b1, 5'd7,  32'h00000055, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd31, 32'h00000066, 1'b1, 1'b0, 5'd0,  32'd0,        1'b1};
        vecs[5]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd30, 32'h00000067, 1'b1, 1'b0, 5'd0,  32'd0,        1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'h00000068, 1'b1, 1'b0, 5'd0,  32'd0,        1'b1};
        vecs[7]  = '{1'b1, 5'd0,  32'h11111111, 1'b1, 5'd12, 32'h000000A5, 1'b1, 1'b1, 5'd12, 32'h000000A5, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 5'd0,  32'd0,        1'b0};
        vecs[9]  = '{1'b1, 5'd31, 32'h0000CAFE, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 5'd31, 32'h0000CAFE, 1'b0};
        vecs[10] = '{1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 5'd30, 32'h00000099, 1'b0, 1'b1, 5'd1,  32'hFFFFFFFF, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd1,  32'h00000077, 1'b1, 1'b1, 5'd1,  32'h00000077, 1'b0};

        // Reset state, with a NoC request present to show READY is forced low.
        idle_inputs();
        RESET = 1'b0;
        NOC_VALID = 1'b1; NOC_ADDR = 5'd7;
        tick();
        tick();
        chk("rst we", WRITE_EN, 1'b0);
        chk("rst addr", IN_ADDRESS, 5'd0);
        chk("rst data", DATA_IN, 32'd0);
        chk("rst ack", ISR_ACK, 1'b0);
        chk("rst err", NOC_ERR, 1'b0);
        chk("rst ovr", RAND_OVERRUN, 1'b0);
        chk("rst ready", NOC_READY, 1'b0);
        idle_inputs();
        RESET = 1'b1;

        // Table: 12 single-cycle vectors, all finished before the first RAND expiry.
        for (int i = 0; i < 12; i++) begin
            WB_WE = vecs[i].wb_we; WB_ADDR = vecs[i].wb_addr; WB_DATA = vecs[i].wb_data;
            NOC_VALID = vecs[i].noc_valid; NOC_ADDR = vecs[i].noc_addr; NOC_DATA = vecs[i].noc_data;
            #1;
            chk($sformatf("vec%0d ready", i), NOC_READY, vecs[i].exp_ready);
            tick();
            chk($sformatf("vec%0d we", i), WRITE_EN, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d addr", i), IN_ADDRESS, vecs[i].exp_addr);
                chk($sformatf("vec%0d data", i), DATA_IN, vecs[i].exp_data);
            end
            chk($sformatf("vec%0d err", i), NOC_ERR, vecs[i].exp_err);
            $display("vec%0d: we=%0b addr=%0d data=0x%08h err=%0b", i, WRITE_EN, IN_ADDRESS, DATA_IN, NOC_ERR);
        end
        idle_inputs();

        // First RAND refresh lands at edge P+1 with RAND_IN from the grant cycle.
        do_reset();
        for (int j = 1; j <= P + 3; j++) begin
            tick();
            chk($sformatf("rand t%0d we", j), WRITE_EN, (j == P + 1));
            if (j == P + 1) begin
                chk("rand addr", IN_ADDRESS, 5'd31);
                chk("rand data", DATA_IN, 32'h1000_0000 + P);
                $display("rand write: edge=%0d data=0x%08h", j, DATA_IN);
            end
            RAND_IN = 32'h1000_0000 + j;
        end

        // ISR save delayed by three WB writes, one ACK, no repeat while held.
        do_reset();
        ISR_REQ = 1'b1; ISR_PC = 32'h100;
        WB_WE = 1'b1; WB_ADDR = 5'd3;
        for (int k = 0; k < 3; k++) begin
            WB_DATA = k + 1;
            tick();
            chk($sformatf("isr wb%0d we", k), WRITE_EN, 1'b1);
            chk($sformatf("isr wb%0d data", k), DATA_IN, k + 1);
            chk($sformatf("isr wb%0d ack", k), ISR_ACK, 1'b0);
        end
        WB_WE = 1'b0;
        tick();
        chk("isr save we", WRITE_EN, 1'b1);
        chk("isr save addr", IN_ADDRESS, 5'd30);
        chk("isr save data", DATA_IN, 32'h100);
        chk("isr ack", ISR_ACK, 1'b1);
        $display("isr save: addr=%0d data=0x%08h ack=%0b", IN_ADDRESS, DATA_IN, ISR_ACK);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("isr hold%0d we", k), WRITE_EN, 1'b0);
            chk($sformatf("isr hold%0d ack", k), ISR_ACK, 1'b0);
        end
        ISR_REQ = 1'b0;
        tick();
        chk("isr drop we", WRITE_EN, 1'b0);
        ISR_REQ = 1'b1; ISR_PC = 32'h200;
        tick();
        chk("isr2 enter we", WRITE_EN, 1'b0);
        tick();
        chk("isr2 we", WRITE_EN, 1'b1);
        chk("isr2 data", DATA_IN, 32'h200);
        chk("isr2 ack", ISR_ACK, 1'b1);
        tick();
        chk("isr2 ack end", ISR_ACK, 1'b0);

        // Sustained WB starves RAND: overrun at edge 2P, then a single RAND write.
        do_reset();
        WB_WE = 1'b1; WB_ADDR = 5'd2; WB_DATA = 32'h22;
        for (int j = 1; j <= 2 * P; j++) begin
            tick();
            if (j == 2 * P - 1) chk("ovr early", RAND_OVERRUN, 1'b0);
        end
        chk("ovr set", RAND_OVERRUN, 1'b1);
        WB_WE = 1'b0; RAND_IN = 32'hABCD0001;
        tick();
        chk("ovr rand we", WRITE_EN, 1'b1);
        chk("ovr rand addr", IN_ADDRESS, 5'd31);
        chk("ovr rand data", DATA_IN, 32'hABCD0001);
        $display("overrun rand write: data=0x%08h ovr=%0b", DATA_IN, RAND_OVERRUN);
        RAND_IN = 32'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("ovr after%0d we", k), WRITE_EN, 1'b0);
            chk($sformatf("ovr after%0d sticky", k), RAND_OVERRUN, 1'b1);
        end
        do_reset();
        chk("ovr cleared", RAND_OVERRUN, 1'b0);

        // Reset while the save is pending: no ACK ever appears.
        do_reset();
        ISR_REQ = 1'b1; ISR_PC = 32'h300;
        WB_WE = 1'b1; WB_ADDR = 5'd4; WB_DATA = 32'h44;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        chk("midrst we", WRITE_EN, 1'b0);
        chk("midrst ack", ISR_ACK, 1'b0);
        idle_inputs();
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst post%0d ack", k), ISR_ACK, 1'b0);
            chk($sformatf("midrst post%0d we", k), WRITE_EN, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
